// File: rtl/decode_scoreboard.sv
// decode_scoreboard: ID-stage register scoreboard with per-register latency
// countdowns (RAW and WAW interlock) plus an optional LL/SC link tracker.
// Define DECODE_SCOREBOARD_LLSC_EN to build the link FSM; without it the
// atomic outputs are tied low and the LL/SC/store/link_clear inputs are ignored.
module decode_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int MUL_LATENCY  = 4,
  parameter int LOAD_LATENCY = 2,
  localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CW          = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_reads_rs,
  input  logic          id_reads_rt,
  input  logic [AW-1:0] id_dest_addr,
  input  logic          id_dest_we,
  input  logic          id_is_mul,
  input  logic          id_is_load,
  input  logic          id_is_ll,
  input  logic          id_is_sc,
  input  logic          id_is_store,
  input  logic          link_clear,
  output logic          stall,
  output logic          atomic_id,
  output logic          mem_sc_mask_id,
  output logic          sb_busy
);

  // Countdown per register; entry 0 is held at zero so r0 is never pending.
  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic [CW-1:0] new_lat;
  logic          rs_pend, rt_pend, waw, dest_live, issue;

  // Latency the instruction in ID would load into its destination counter.
  always_comb begin
    new_lat = '0;
    if (id_is_mul)       new_lat = CW'(MUL_LATENCY);
    else if (id_is_load) new_lat = CW'(LOAD_LATENCY);
  end

  // Interlock: value forwardable once its counter reaches 1, so pending is >1.
  // WAW holds the newer writer until the older one would finish no later.
  always_comb begin
    dest_live = id_dest_we && (id_dest_addr != '0);
    rs_pend   = id_reads_rs && (cnt_q[id_rs_addr] > CW'(1));
    rt_pend   = id_reads_rt && (cnt_q[id_rt_addr] > CW'(1));
    waw       = dest_live && (cnt_q[id_dest_addr] > new_lat);
    stall     = id_valid && (rs_pend || rt_pend || waw);
    issue     = id_valid && !stall;
  end

  // Next counter values: load on issue, otherwise count down to zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && dest_live && (id_dest_addr == AW'(r)) &&
                   (new_lat != '0)) begin
        cnt_d[r] = new_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  // Counter state; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Busy whenever any counter has not drained.
  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) sb_busy = sb_busy | (cnt_q[r] != '0);
  end

`ifdef DECODE_SCOREBOARD_LLSC_EN
  typedef enum logic {IDLE, LINKED} link_st_e;
  link_st_e link_q;

  // Link tracker: link_clear wins over an LL issuing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= IDLE;
    end else begin
      case (link_q)
        IDLE:    if (issue && id_is_ll && !link_clear) link_q <= LINKED;
        LINKED:  if (link_clear || (issue && (id_is_sc || id_is_store))) link_q <= IDLE;
        default: link_q <= IDLE;
      endcase
    end
  end

  assign atomic_id      = (link_q == LINKED);
  assign mem_sc_mask_id = id_valid && id_is_sc && (link_q == IDLE);
`else
  logic unused_llsc;
  assign unused_llsc    = ^{id_is_ll, id_is_sc, id_is_store, link_clear};
  assign atomic_id      = 1'b0;
  assign mem_sc_mask_id = 1'b0;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed vector table, a mid-operation reset
// sequence, and random traffic against a counter-array reference model.
module tb_decode_scoreboard;
  localparam int AW = 5;
`ifdef DECODE_SCOREBOARD_LLSC_EN
  localparam bit L = 1'b1;
`else
  localparam bit L = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_reads_rs, id_reads_rt, id_dest_we;
  logic id_is_mul, id_is_load, id_is_ll, id_is_sc, id_is_store, link_clear;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_dest_addr;
  logic stall, atomic_id, mem_sc_mask_id, sb_busy;

  decode_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt),
    .id_dest_addr(id_dest_addr), .id_dest_we(id_dest_we),
    .id_is_mul(id_is_mul), .id_is_load(id_is_load), .id_is_ll(id_is_ll),
    .id_is_sc(id_is_sc), .id_is_store(id_is_store), .link_clear(link_clear),
    .stall(stall), .atomic_id(atomic_id), .mem_sc_mask_id(mem_sc_mask_id),
    .sb_busy(sb_busy));

  always #5 clk = ~clk;

  typedef struct {
    bit valid; int rs, rt; bit rrs, rrt; int dest;
    bit we, mul, ld, ll, sc, st, lc;
    bit es, eb, ea, em;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0, n_fail = 0;

  // Reference model: remaining cycles per register and a link flag.
  int m_cnt[32], m_cnt_n[32];
  bit m_link, m_link_n;

  function automatic vec_t mk(bit v, int rs, int rt, bit rrs, bit rrt, int dest,
                              bit we, bit mul, bit ld, bit ll, bit sc, bit st, bit lc,
                              bit es, bit eb, bit ea, bit em);
    vec_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.rrs = rrs; t.rrt = rrt; t.dest = dest;
    t.we = we; t.mul = mul; t.ld = ld; t.ll = ll; t.sc = sc; t.st = st; t.lc = lc;
    t.es = es; t.eb = eb; t.ea = ea; t.em = em;
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.valid; id_rs_addr = AW'(t.rs); id_rt_addr = AW'(t.rt);
    id_reads_rs = t.rrs; id_reads_rt = t.rrt; id_dest_addr = AW'(t.dest);
    id_dest_we = t.we; id_is_mul = t.mul; id_is_load = t.ld; id_is_ll = t.ll;
    id_is_sc = t.sc; id_is_store = t.st; link_clear = t.lc;
  endtask

  task automatic chk(string nm, int idx, logic got, logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0b expected=%0b", nm, idx, got, exp);
    end
  endtask

  function automatic int lat(vec_t t);
    return t.mul ? 4 : (t.ld ? 2 : 0);
  endfunction

  function automatic bit m_stall(vec_t t);
    bit s;
    s = (t.rrs && m_cnt[t.rs] > 1) || (t.rrt && m_cnt[t.rt] > 1) ||
        (t.we && t.dest != 0 && m_cnt[t.dest] > lat(t));
    return t.valid && s;
  endfunction

  function automatic bit m_busy();
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Compute the model's next state from the current inputs (before the edge).
  task automatic model_next(vec_t t);
    bit iss;
    iss = t.valid && !m_stall(t);
    for (int r = 0; r < 32; r++) begin
      if (iss && t.we && t.dest == r && r != 0 && lat(t) > 0) m_cnt_n[r] = lat(t);
      else m_cnt_n[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    end
    m_link_n = m_link;
    if (L) begin
      if (t.lc) m_link_n = 1'b0;
      else if (iss && (t.sc || t.st)) m_link_n = 1'b0;
      else if (iss && t.ll) m_link_n = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_link = 1'b0;
  endtask

  // One cycle: drive, check at the falling edge, advance model at the rising edge.
  task automatic cycle(vec_t t, bit use_tbl, int idx);
    drive(t);
    @(negedge clk);
    if (use_tbl) begin
      chk("tbl_stall", idx, stall, t.es);
      chk("tbl_busy", idx, sb_busy, t.eb);
      chk("tbl_atomic", idx, atomic_id, t.ea);
      chk("tbl_mask", idx, mem_sc_mask_id, t.em);
    end else begin
      chk("rnd_stall", idx, stall, m_stall(t));
      chk("rnd_busy", idx, sb_busy, m_busy());
      chk("rnd_atomic", idx, atomic_id, m_link);
      chk("rnd_mask", idx, mem_sc_mask_id, L && t.valid && t.sc && !m_link);
    end
    model_next(t);
    @(posedge clk);
    m_cnt = m_cnt_n;
    m_link = m_link_n;
    #1;
  endtask

  initial begin
    vec_t idle, t;
    idle = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0);
    // MUL r5 then ADD reading r5 (stall 3 cycles).
    tbl.push_back(mk(1,0,0,0,0,5, 1,1,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,5,0,1,0,6, 1,0,0,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,5,0,1,0,6, 1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // LW r8 then SW reading rt=r8; r0 never pending.
    tbl.push_back(mk(1,0,0,0,0,8, 1,0,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,8,1,1,0, 0,0,0,0,0,1,0, 1,1,0,0));
    tbl.push_back(mk(1,0,8,1,1,0, 0,0,0,0,0,1,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,1,1,0, 0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,1,1,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // MUL r3 then LW r3: WAW stall two cycles.
    tbl.push_back(mk(1,0,0,0,0,3, 1,1,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0,3, 1,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,3, 1,0,1,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // LL ... SC keeps the store.
    tbl.push_back(mk(1,0,0,0,0,9, 1,0,1,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,L,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,L,0));
    tbl.push_back(mk(1,0,0,0,0,10,1,0,0,0,1,0,0, 0,0,L,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // LL, SW breaks the link, SC is masked.
    tbl.push_back(mk(1,0,0,0,0,9, 1,0,1,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,L,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,1,0, 0,1,L,0));
    tbl.push_back(mk(1,0,0,0,0,10,1,0,0,0,1,0,0, 0,0,0,L));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // LL with same-cycle link_clear never links.
    tbl.push_back(mk(1,0,0,0,0,9, 1,0,1,1,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // Stalled LL changes nothing; invalid ID never stalls.
    tbl.push_back(mk(1,0,0,0,0,4, 1,1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,4,0,1,0,9, 1,0,1,1,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,4,0,1,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));

    // Reset state.
    drive(idle);
    model_reset();
    #3;
    chk("rst_stall", 0, stall, 1'b0);
    chk("rst_busy", 0, sb_busy, 1'b0);
    chk("rst_atomic", 0, atomic_id, 1'b0);
    chk("rst_mask", 0, mem_sc_mask_id, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) cycle(tbl[i], 1'b1, i);

    // Reset pulsed while a MUL is pending and a dependent op is stalled.
    cycle(mk(1,0,0,0,0,5, 1,1,0,0,0,0,0, 0,0,0,0), 1'b0, 0);
    drive(mk(1,5,0,1,0,6, 1,0,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    chk("midrst_pre_stall", 0, stall, 1'b1);
    chk("midrst_pre_busy", 0, sb_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 0, stall, 1'b0);
    chk("midrst_busy", 0, sb_busy, 1'b0);
    model_reset();
    drive(idle);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int cls;
      t = idle;
      t.valid = ($urandom_range(0, 3) != 0);
      t.rs = $urandom_range(0, 7); t.rt = $urandom_range(0, 7);
      t.rrs = $urandom_range(0, 1); t.rrt = $urandom_range(0, 1);
      t.dest = $urandom_range(0, 7); t.we = $urandom_range(0, 1);
      cls = $urandom_range(0, 5);
      t.mul = (cls == 0); t.ld = (cls == 1 || cls == 2); t.ll = (cls == 2);
      t.sc = (cls == 3); t.st = (cls == 4);
      t.lc = ($urandom_range(0, 9) == 0);
      cycle(t, 1'b0, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
